// File: rtl/uart_reg_bridge_if.sv
`default_nettype none
// ============================================================================
// uart_reg_bridge_if : UART FIFO ports and local register bus of the bridge.
// Revision: 1.0
// ============================================================================
interface uart_reg_bridge_if #(
    parameter int DATA_BITS  = 8,
    parameter int ADDR_WIDTH = 4
) ();
    logic                  rx_ready;
    logic [DATA_BITS-1:0]  rx_data;
    logic                  rx_rd;
    logic                  tx_full;
    logic                  tx_wr;
    logic [DATA_BITS-1:0]  tx_data;
    logic                  reg_wr;
    logic                  reg_rd;
    logic [ADDR_WIDTH-1:0] reg_addr;
    logic [DATA_BITS-1:0]  reg_wdata;
    logic [DATA_BITS-1:0]  reg_rdata;
    logic                  frame_err;

    modport master (
        input  rx_ready, rx_data, tx_full, reg_rdata,
        output rx_rd, tx_wr, tx_data, reg_wr, reg_rd, reg_addr, reg_wdata, frame_err
    );

    modport slave (
        output rx_ready, rx_data, tx_full, reg_rdata,
        input  rx_rd, tx_wr, tx_data, reg_wr, reg_rd, reg_addr, reg_wdata, frame_err
    );
endinterface
`default_nettype wire

// File: rtl/uart_reg_bridge.sv
`default_nettype none
// ============================================================================
// uart_reg_bridge : pops command frames from the UART RX FIFO, runs register
// cycles and pushes one response byte. Macro UART_BRIDGE_CHKSUM_EN adds a
// trailing XOR checksum byte to every frame.
// Revision: 1.0
// ============================================================================
module uart_reg_bridge #(
    parameter int DATA_BITS      = 8,
    parameter int ADDR_WIDTH     = 4,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input wire                clk,
    input wire                rst_n,
    uart_reg_bridge_if.master bus
);
    localparam int                   c_tmo_w    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_tmo_w-1:0]   c_tmo_last = c_tmo_w'(TIMEOUT_CYCLES - 1);
    localparam logic [DATA_BITS-1:0] c_cmd_wr   = DATA_BITS'(8'h57);
    localparam logic [DATA_BITS-1:0] c_cmd_rd   = DATA_BITS'(8'h52);
    localparam logic [DATA_BITS-1:0] c_ack      = DATA_BITS'(8'h06);
    localparam logic [DATA_BITS-1:0] c_nak      = DATA_BITS'(8'h15);

    localparam logic [2:0] c_st_idle     = 3'd0;
    localparam logic [2:0] c_st_get_addr = 3'd1;
    localparam logic [2:0] c_st_get_data = 3'd2;
`ifdef UART_BRIDGE_CHKSUM_EN
    localparam logic [2:0] c_st_get_chk  = 3'd3;
`endif
    localparam logic [2:0] c_st_exec     = 3'd4;
    localparam logic [2:0] c_st_rd_wait  = 3'd5;
    localparam logic [2:0] c_st_send     = 3'd6;

    logic [2:0]            r_state;
    logic [2:0]            w_state_nxt;
    logic [DATA_BITS-1:0]  r_resp;
    logic                  r_nak;
    logic                  r_is_wr;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_addr_bad;
    logic [DATA_BITS-1:0]  r_wdata;
    logic [c_tmo_w-1:0]    r_tmo;
    logic                  w_in_get;
    logic                  w_pop;
    logic                  w_timeout;
    logic                  w_push;
    logic                  w_cmd_ok;
    logic                  w_addr_bad_in;
`ifdef UART_BRIDGE_CHKSUM_EN
    logic [DATA_BITS-1:0]  r_chk;
    logic                  w_chk_ok;
    assign w_chk_ok = (bus.rx_data == r_chk);
`endif

    always_comb begin
        w_in_get = (r_state == c_st_get_addr) || (r_state == c_st_get_data);
`ifdef UART_BRIDGE_CHKSUM_EN
        w_in_get = w_in_get || (r_state == c_st_get_chk);
`endif
    end

    // rst_n gate keeps rx_rd low while the bridge is held in reset
    assign w_pop         = rst_n && bus.rx_ready && ((r_state == c_st_idle) || w_in_get);
    assign w_timeout     = w_in_get && !bus.rx_ready && (r_tmo == c_tmo_last);
    assign w_push        = (r_state == c_st_send) && !bus.tx_full;
    assign w_cmd_ok      = (bus.rx_data == c_cmd_wr) || (bus.rx_data == c_cmd_rd);
    assign w_addr_bad_in = ((bus.rx_data >> ADDR_WIDTH) != '0);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_pop) w_state_nxt = w_cmd_ok ? c_st_get_addr : c_st_send;
            end
            c_st_get_addr: begin
                if (w_pop) begin
                    if (r_is_wr) w_state_nxt = c_st_get_data;
`ifdef UART_BRIDGE_CHKSUM_EN
                    else         w_state_nxt = c_st_get_chk;
`else
                    else         w_state_nxt = w_addr_bad_in ? c_st_send : c_st_exec;
`endif
                end else if (w_timeout) begin
                    w_state_nxt = c_st_idle;
                end
            end
            c_st_get_data: begin
                if (w_pop) begin
`ifdef UART_BRIDGE_CHKSUM_EN
                    w_state_nxt = c_st_get_chk;
`else
                    w_state_nxt = r_addr_bad ? c_st_send : c_st_exec;
`endif
                end else if (w_timeout) begin
                    w_state_nxt = c_st_idle;
                end
            end
`ifdef UART_BRIDGE_CHKSUM_EN
            c_st_get_chk: begin
                if (w_pop)          w_state_nxt = (r_addr_bad || !w_chk_ok) ? c_st_send : c_st_exec;
                else if (w_timeout) w_state_nxt = c_st_idle;
            end
`endif
            c_st_exec:    w_state_nxt = r_is_wr ? c_st_send : c_st_rd_wait;
            c_st_rd_wait: w_state_nxt = c_st_send;
            c_st_send: begin
                if (w_push) w_state_nxt = c_st_idle;
            end
            default:      w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_st_idle;
            r_tmo      <= '0;
            r_resp     <= '0;
            r_nak      <= 1'b0;
            r_is_wr    <= 1'b0;
            r_addr     <= '0;
            r_addr_bad <= 1'b0;
            r_wdata    <= '0;
`ifdef UART_BRIDGE_CHKSUM_EN
            r_chk      <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_tmo   <= (w_pop || !w_in_get) ? '0 : r_tmo + c_tmo_w'(1);
            if (w_pop) begin
                case (r_state)
                    c_st_idle: begin
                        r_is_wr    <= (bus.rx_data == c_cmd_wr);
                        r_addr_bad <= 1'b0;
                    end
                    c_st_get_addr: begin
                        r_addr     <= bus.rx_data[ADDR_WIDTH-1:0];
                        r_addr_bad <= w_addr_bad_in;
                    end
                    c_st_get_data: r_wdata <= bus.rx_data;
                    default: ;
                endcase
`ifdef UART_BRIDGE_CHKSUM_EN
                r_chk <= (r_state == c_st_idle) ? bus.rx_data : (r_chk ^ bus.rx_data);
`endif
                // any frame that ends without reaching EXEC is answered with NAK
                if (w_state_nxt == c_st_send) begin
                    r_resp <= c_nak;
                    r_nak  <= 1'b1;
                end
            end
            if ((r_state == c_st_exec) && r_is_wr) begin
                r_resp <= c_ack;
                r_nak  <= 1'b0;
            end
            if (r_state == c_st_rd_wait) begin
                r_resp <= bus.reg_rdata;
                r_nak  <= 1'b0;
            end
        end
    end

    assign bus.rx_rd     = w_pop;
    assign bus.tx_wr     = w_push;
    assign bus.tx_data   = r_resp;
    assign bus.reg_wr    = (r_state == c_st_exec) && r_is_wr;
    assign bus.reg_rd    = (r_state == c_st_exec) && !r_is_wr;
    assign bus.reg_addr  = r_addr;
    assign bus.reg_wdata = r_wdata;
    assign bus.frame_err = (w_push && r_nak) || w_timeout;
endmodule
`default_nettype wire
